mem_access_unit: RTL and testbench

Multicycle memory-access sequencer sitting directly upstream of the byte/half load-management stage. It takes a load/store request from the control unit, drives the word-addressed synchronous memory, and captures the load word into the memory data register (MDR). The MDR is realigned so the addressed byte/half lands in the LSBs. Sub-word stores (SB/SH) run as read-modify-write with lane merging. Misaligned word/half accesses are trapped without touching memory.

---
 rtl/mem_pkg.sv | 36 +++
 rtl/mem_access_unit_if.sv | 29 ++
 rtl/store_merge.sv | 25 ++
 rtl/mem_access_unit.sv | 150 +++++++++++++++
 tb/tb_mem_access_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the multicycle memory-access sequencer: access-type
// encodings, FSM state encoding, default latency and alignment helpers.
package mem_pkg;

    localparam int MEM_LATENCY_DEFAULT = 1;

    // Access types; bit 2 set means store. Codes 3 and 7 are reserved.
    localparam logic [2:0] OP_LW = 3'd0;
    localparam logic [2:0] OP_LH = 3'd1;
    localparam logic [2:0] OP_LB = 3'd2;
    localparam logic [2:0] OP_SW = 3'd4;
    localparam logic [2:0] OP_SH = 3'd5;
    localparam logic [2:0] OP_SB = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_FAULT  = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    // Word accesses need addr[1:0]==0, half accesses need addr[0]==0.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        case (op)
            OP_LW, OP_SW: return addr_lo != 2'b00;
            OP_LH, OP_SH: return addr_lo[0];
            default:      return 1'b0;
        endcase
    endfunction

    function automatic logic is_reserved(input logic [2:0] op);
        return (op == 3'd3) || (op == 3'd7);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and memory-bus signals of the memory-access sequencer.
// slave is the sequencer's view; master is the view of its surroundings
// (control unit issuing requests plus the memory returning read data).
interface mem_access_unit_if;

    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        misalign;
    logic [31:0] mdr;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req, op, addr, wdata, mem_rdata,
        output busy, done, misalign, mdr, mem_addr, mem_wr, mem_wdata
    );

    modport master (
        output req, op, addr, wdata, mem_rdata,
        input  busy, done, misalign, mdr, mem_addr, mem_wr, mem_wdata
    );

endinterface

// File: rtl/store_merge.sv
// Lane merge for sub-word stores: replaces the addressed byte or half of the
// old memory word with the LSBs of the store data. SW passes wdata through.
module store_merge
    import mem_pkg::*;
(
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_op,
    output logic [31:0] o_merged
);

    // Start from the old word and overwrite only the target lane.
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        o_merged = i_old_word;
        case (i_op)
            OP_SB:   o_merged[{i_addr_lo, 3'b000} +: 8]     = i_wdata[7:0];
            OP_SH:   o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
            OP_SW:   o_merged = i_wdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multicycle memory-access sequencer: runs loads, word stores and
// read-modify-write sub-word stores against a word-addressed synchronous
// memory, realigns load data into the MDR and traps misaligned or reserved ops.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    mem_access_unit_if.slave bus
);

    localparam int               CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    state_e           r_state;
    state_e           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    logic [1:0]       r_addr_lo;
    logic [31:0]      r_wdata;
    logic             r_misalign;
    logic [31:0]      r_mdr;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;

    logic             w_last_read;
    logic             w_req_fault;
    logic             w_busy;
    logic             w_done;
    logic             w_misalign;
    logic             w_mem_wr;
    logic [31:0]      w_merged;
    logic [31:0]      w_realigned;

    assign w_last_read = (r_cnt == CNT_LAST);
    assign w_req_fault = is_misaligned(bus.op, bus.addr[1:0]) || is_reserved(bus.op);

    store_merge u_store_merge (
        .i_old_word (bus.mem_rdata),
        .i_wdata    (r_wdata),
        .i_addr_lo  (r_addr_lo),
        .i_op       (r_op),
        .o_merged   (w_merged)
    );

    // Shift the addressed byte/half of the read word down to the LSBs; upper bits keep the remainder.
    always_comb begin
        w_realigned = bus.mem_rdata;
        case (r_op)
            OP_LB:   w_realigned = bus.mem_rdata >> {r_addr_lo, 3'b000};
            OP_LH:   w_realigned = bus.mem_rdata >> {r_addr_lo[1], 4'b0000};
            default: ;
        endcase
    end

    // State register; reset returns to IDLE, which also drops mem_wr at once.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state decision and status outputs decoded from the registered state.
    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        w_misalign   = 1'b0;
        w_mem_wr     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (bus.req) begin
                    if (w_req_fault)          w_next_state = ST_FAULT;
                    else if (bus.op == OP_SW) w_next_state = ST_WRITE;
                    else                      w_next_state = ST_READ;
                end
            end
            ST_READ: begin
                // Only loads and SB/SH come through READ; the stores continue to WRITE.
                if (w_last_read) w_next_state = r_op[2] ? ST_WRITE : ST_FINISH;
            end
            ST_WRITE: begin
                w_mem_wr     = 1'b1;
                w_next_state = ST_FINISH;
            end
            ST_FAULT: begin
                w_done       = 1'b1;
                w_misalign   = r_misalign;
                w_next_state = ST_IDLE;
            end
            ST_FINISH: begin
                w_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Request latch, latency counter, MDR capture and merged store word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: MDR and the write word are ordinary registers, so they are cleared like any other state.
            r_cnt       <= '0;
            r_op        <= OP_LW;
            r_addr_lo   <= 2'b00;
            r_wdata     <= '0;
            r_misalign  <= 1'b0;
            r_mdr       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req) begin
                        r_op       <= bus.op;
                        r_addr_lo  <= bus.addr[1:0];
                        r_wdata    <= bus.wdata;
                        r_misalign <= is_misaligned(bus.op, bus.addr[1:0]);
                        r_cnt      <= '0;
                        if (!w_req_fault) begin
                            r_mem_addr <= {bus.addr[31:2], 2'b00};
                            if (bus.op == OP_SW) r_mem_wdata <= bus.wdata;
                        end
                    end
                end
                ST_READ: begin
                    if (w_last_read) begin
                        if (r_op[2]) r_mem_wdata <= w_merged;
                        else         r_mdr       <= w_realigned;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.misalign  = w_misalign;
    assign bus.mem_wr    = w_mem_wr;
    assign bus.mdr       = r_mdr;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (latency 1 and 3) each with a
// word memory model; directed vectors from a table, hand-written reset and
// back-to-back sequences, then random accesses against a reference model.
module tb_mem_access_unit;
    import mem_pkg::*;

    typedef struct {
        logic        busy;
        logic        done;
        logic        misalign;
        logic        mem_wr;
        logic [31:0] mdr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
    } outs_t;

    typedef struct {
        int          done_cyc;
        logic        mis;
        logic [31:0] mdr;
        int          wr_cnt;
        logic [31:0] word;
    } exp_t;

    typedef struct {
        string       nm;
        int          d;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word;
        int          e_done;
        logic        e_mis;
        logic [31:0] e_mdr;
        int          e_wr;
        logic [31:0] e_word;
    } vec_t;

    logic clk;
    logic reset;

    mem_access_unit_if ifc0 ();
    mem_access_unit_if ifc1 ();

    mem_access_unit #(.MEM_LATENCY(1)) u_dut_l1 (.clk(clk), .reset(reset), .bus(ifc0.slave));
    mem_access_unit #(.MEM_LATENCY(3)) u_dut_l3 (.clk(clk), .reset(reset), .bus(ifc1.slave));

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] model_mdr [2];

    // Memory models: 256 words each, written by the DUT or by a bench poke.
    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];
    logic [31:0] pipe1 [2];
    logic        poke_en [2];
    logic [7:0]  poke_idx;
    logic [31:0] poke_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ifc0.mem_wr) mem0[ifc0.mem_addr[9:2]] <= ifc0.mem_wdata;
        if (poke_en[0])  mem0[poke_idx] <= poke_val;
        if (ifc1.mem_wr) mem1[ifc1.mem_addr[9:2]] <= ifc1.mem_wdata;
        if (poke_en[1])  mem1[poke_idx] <= poke_val;
        pipe1[0] <= mem1[ifc1.mem_addr[9:2]];
        pipe1[1] <= pipe1[0];
    end

    // Latency 1: data valid in the cycle the address is presented.
    assign ifc0.mem_rdata = mem0[ifc0.mem_addr[9:2]];
    // Latency 3: two extra register stages.
    assign ifc1.mem_rdata = pipe1[1];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic outs_t sample(input int d);
        outs_t o;
        if (d == 0) begin
            o.busy = ifc0.busy; o.done = ifc0.done; o.misalign = ifc0.misalign;
            o.mem_wr = ifc0.mem_wr; o.mdr = ifc0.mdr; o.mem_addr = ifc0.mem_addr;
            o.mem_wdata = ifc0.mem_wdata;
        end else begin
            o.busy = ifc1.busy; o.done = ifc1.done; o.misalign = ifc1.misalign;
            o.mem_wr = ifc1.mem_wr; o.mdr = ifc1.mdr; o.mem_addr = ifc1.mem_addr;
            o.mem_wdata = ifc1.mem_wdata;
        end
        return o;
    endfunction

    task automatic drive(input int d, input logic rq, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] w);
        if (d == 0) begin
            ifc0.req = rq; ifc0.op = op; ifc0.addr = a; ifc0.wdata = w;
        end else begin
            ifc1.req = rq; ifc1.op = op; ifc1.addr = a; ifc1.wdata = w;
        end
    endtask

    function automatic logic [31:0] peek(input int d, input logic [7:0] idx);
        return (d == 0) ? mem0[idx] : mem1[idx];
    endfunction

    task automatic poke(input int d, input logic [7:0] idx, input logic [31:0] val);
        @(negedge clk);
        poke_idx   = idx;
        poke_val   = val;
        poke_en[d] = 1'b1;
        @(posedge clk);
        #1 poke_en[d] = 1'b0;
    endtask

    // Reference behaviour from the access rules, independent of any state machine.
    function automatic exp_t ref_model(input int lat, input logic [2:0] op, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [31:0] word,
                                       input logic [31:0] mdr_before);
        exp_t e;
        int k;
        logic [31:0] mask;
        k = int'(addr % 4);
        e.mdr = mdr_before; e.word = word; e.wr_cnt = 0; e.mis = 1'b0; e.done_cyc = 1;
        if (op == 3'd3 || op == 3'd7) begin
            e.done_cyc = 1;
        end else if (((op == OP_LW || op == OP_SW) && k != 0) ||
                     ((op == OP_LH || op == OP_SH) && (k % 2) != 0)) begin
            e.done_cyc = 1;
            e.mis = 1'b1;
        end else begin
            case (op)
                OP_LW: begin e.done_cyc = lat + 1; e.mdr = word; end
                OP_LH: begin e.done_cyc = lat + 1; e.mdr = word >> (16 * (k / 2)); end
                OP_LB: begin e.done_cyc = lat + 1; e.mdr = word >> (8 * k); end
                OP_SW: begin e.done_cyc = 2; e.wr_cnt = 1; e.word = wdata; end
                default: begin
                    mask = (op == OP_SH) ? 32'h0000_FFFF : 32'h0000_00FF;
                    e.word = (word & ~(mask << (8 * k))) | ((wdata & mask) << (8 * k));
                    e.done_cyc = lat + 2;
                    e.wr_cnt = 1;
                end
            endcase
        end
        return e;
    endfunction

    // Issue one request (sampled at "edge 0"), toggle junk requests while busy,
    // and record what the DUT did cycle by cycle until done.
    task automatic run_access(input int d, input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, output int done_cyc, output logic mis,
                              output logic [31:0] mdr_v, output int wr_cnt,
                              output logic [31:0] wr_data, output logic idle_after);
        outs_t o;
        done_cyc = -1; mis = 1'b0; mdr_v = '0; wr_cnt = 0; wr_data = '0;
        @(negedge clk);
        drive(d, 1'b1, op, addr, wdata);
        @(posedge clk);
        for (int c = 1; c <= 20 && done_cyc < 0; c++) begin
            @(negedge clk);
            o = sample(d);
            if (o.mem_wr) begin
                wr_cnt++;
                wr_data = o.mem_wdata;
            end
            if (o.done) begin
                done_cyc = c;
                mis = o.misalign;
                mdr_v = o.mdr;
                drive(d, 1'b0, 3'd0, 32'd0, 32'd0);
            end else begin
                drive(d, 1'($urandom), 3'($urandom), $urandom, $urandom);
            end
        end
        drive(d, 1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        o = sample(d);
        idle_after = !o.busy && !o.done && !o.mem_wr;
    endtask

    task automatic run_and_check(input string nm, input int d, input logic [2:0] op,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] word, input exp_t e);
        int done_cyc, wr_cnt;
        logic mis, idle_after;
        logic [31:0] mdr_v, wr_data;
        poke(d, addr[9:2], word);
        run_access(d, op, addr, wdata, done_cyc, mis, mdr_v, wr_cnt, wr_data, idle_after);
        check({nm, " done_cycle"}, 32'(done_cyc), 32'(e.done_cyc));
        check({nm, " misalign"}, 32'(mis), 32'(e.mis));
        check({nm, " mdr"}, mdr_v, e.mdr);
        check({nm, " mem_wr_count"}, 32'(wr_cnt), 32'(e.wr_cnt));
        if (e.wr_cnt == 1) check({nm, " mem_wdata"}, wr_data, e.word);
        check({nm, " memory"}, peek(d, addr[9:2]), e.word);
        check({nm, " idle_after"}, 32'(idle_after), 32'd1);
        model_mdr[d] = e.mdr;
    endtask

    task automatic check_reset_outputs(input string nm, input int d);
        outs_t o;
        o = sample(d);
        check({nm, " busy"}, 32'(o.busy), 32'd0);
        check({nm, " done"}, 32'(o.done), 32'd0);
        check({nm, " misalign"}, 32'(o.misalign), 32'd0);
        check({nm, " mem_wr"}, 32'(o.mem_wr), 32'd0);
        check({nm, " mdr"}, o.mdr, 32'd0);
        check({nm, " mem_addr"}, o.mem_addr, 32'd0);
        check({nm, " mem_wdata"}, o.mem_wdata, 32'd0);
    endtask

    vec_t vecs [21];

    initial begin
        exp_t e;
        outs_t o;
        logic [7:0] done_bits;
        int done_cnt;

        vecs[0]  = '{"lw_10",    0, OP_LW, 32'h10, 32'h0,        32'hDEADBEEF, 2, 1'b0, 32'hDEADBEEF, 0, 32'hDEADBEEF};
        vecs[1]  = '{"lb_13",    0, OP_LB, 32'h13, 32'h0,        32'h88776655, 2, 1'b0, 32'h00000088, 0, 32'h88776655};
        vecs[2]  = '{"lh_12",    0, OP_LH, 32'h12, 32'h0,        32'h88776655, 2, 1'b0, 32'h00008877, 0, 32'h88776655};
        vecs[3]  = '{"lb_11",    0, OP_LB, 32'h11, 32'h0,        32'h88776655, 2, 1'b0, 32'h00887766, 0, 32'h88776655};
        vecs[4]  = '{"lh_10",    0, OP_LH, 32'h10, 32'h0,        32'h88776655, 2, 1'b0, 32'h88776655, 0, 32'h88776655};
        vecs[5]  = '{"sb_21",    0, OP_SB, 32'h21, 32'hFFFFFFAB, 32'h11223344, 3, 1'b0, 32'h88776655, 1, 32'h1122AB44};
        vecs[6]  = '{"sh_31",    0, OP_SH, 32'h31, 32'h0000BEEF, 32'hCAFEF00D, 1, 1'b1, 32'h88776655, 0, 32'hCAFEF00D};
        vecs[7]  = '{"lw_32",    0, OP_LW, 32'h32, 32'h0,        32'hCAFEF00D, 1, 1'b1, 32'h88776655, 0, 32'hCAFEF00D};
        vecs[8]  = '{"rsv3_40",  0, 3'd3,  32'h40, 32'h0,        32'h00000000, 1, 1'b0, 32'h88776655, 0, 32'h00000000};
        vecs[9]  = '{"sw_44",    0, OP_SW, 32'h44, 32'h12345678, 32'h00000000, 2, 1'b0, 32'h88776655, 1, 32'h12345678};
        vecs[10] = '{"sh_4a",    0, OP_SH, 32'h4A, 32'h0000CDEF, 32'hAAAABBBB, 3, 1'b0, 32'h88776655, 1, 32'hCDEFBBBB};
        vecs[11] = '{"sb_48",    0, OP_SB, 32'h48, 32'h00000011, 32'hAAAABBBB, 3, 1'b0, 32'h88776655, 1, 32'hAAAABB11};
        vecs[12] = '{"lb_4a",    0, OP_LB, 32'h4A, 32'h0,        32'hCDEFBBBB, 2, 1'b0, 32'h0000CDEF, 0, 32'hCDEFBBBB};
        vecs[13] = '{"sw_46",    0, OP_SW, 32'h46, 32'h99999999, 32'h12345678, 1, 1'b1, 32'h0000CDEF, 0, 32'h12345678};
        vecs[14] = '{"l3_lw_80", 1, OP_LW, 32'h80, 32'h0,        32'h01020304, 4, 1'b0, 32'h01020304, 0, 32'h01020304};
        vecs[15] = '{"l3_sb_83", 1, OP_SB, 32'h83, 32'h0000005A, 32'h01020304, 5, 1'b0, 32'h01020304, 1, 32'h5A020304};
        vecs[16] = '{"l3_sh_82", 1, OP_SH, 32'h82, 32'h0000BEEF, 32'h01020304, 5, 1'b0, 32'h01020304, 1, 32'hBEEF0304};
        vecs[17] = '{"l3_rsv7",  1, 3'd7,  32'h84, 32'h0,        32'h00000000, 1, 1'b0, 32'h01020304, 0, 32'h00000000};
        vecs[18] = '{"l3_lh_86", 1, OP_LH, 32'h86, 32'h0,        32'h89ABCDEF, 4, 1'b0, 32'h000089AB, 0, 32'h89ABCDEF};
        vecs[19] = '{"l3_sw_8c", 1, OP_SW, 32'h8C, 32'hCAFEBABE, 32'h00000000, 2, 1'b0, 32'h000089AB, 1, 32'hCAFEBABE};
        vecs[20] = '{"l3_lb_8d", 1, OP_LB, 32'h8D, 32'h0,        32'h11223344, 4, 1'b0, 32'h00112233, 0, 32'h11223344};

        poke_en[0] = 1'b0; poke_en[1] = 1'b0; poke_idx = '0; poke_val = '0;
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
        model_mdr[0] = '0; model_mdr[1] = '0;

        // Reset state
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_l1", 0);
        check_reset_outputs("reset_l3", 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("post_reset_l1", 0);

        // Directed vectors
        for (int i = 0; i < 21; i++) begin
            e = '{vecs[i].e_done, vecs[i].e_mis, vecs[i].e_mdr, vecs[i].e_wr, vecs[i].e_word};
            run_and_check(vecs[i].nm, vecs[i].d, vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].word, e);
        end

        // Back-to-back: req held high relaunches after one idle cycle
        poke(0, 8'h04, 32'h13579BDF);
        @(negedge clk);
        drive(0, 1'b1, OP_LW, 32'h10, 32'h0);
        done_bits = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            o = sample(0);
            done_bits[c-1] = o.done;
            if (c == 3) check("b2b idle_gap_busy", 32'(o.busy), 32'd0);
            if (c == 8) drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
        end
        check("b2b done_pattern", 32'(done_bits), 32'h92);
        check("b2b mdr", ifc0.mdr, 32'h13579BDF);
        model_mdr[0] = 32'h13579BDF;
        repeat (2) @(negedge clk);

        // Reset during the WRITE cycle of an SW on the latency-3 unit
        poke(1, 8'h24, 32'h0BADC0DE);
        @(negedge clk);
        drive(1, 1'b1, OP_SW, 32'h90, 32'hFEEDFACE);
        @(posedge clk);
        #1 drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
        o = sample(1);
        check("rst_wr mem_wr_before", 32'(o.mem_wr), 32'd1);
        #1 reset = 1'b0;
        #1 check_reset_outputs("rst_wr", 1);
        check("rst_wr l1 mdr", ifc0.mdr, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_wr memory", peek(1, 8'h24), 32'h0BADC0DE);
        model_mdr[0] = '0; model_mdr[1] = '0;

        // Reset during READ discards the load and clears mdr
        e = ref_model(3, OP_LW, 32'hA0, 32'h0, 32'h55AA1234, model_mdr[1]);
        run_and_check("pre_rst_rd", 1, OP_LW, 32'hA0, 32'h0, 32'h55AA1234, e);
        @(negedge clk);
        drive(1, 1'b1, OP_LB, 32'hA1, 32'h0);
        @(posedge clk);
        #1 drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_reset_outputs("rst_rd", 1);
        @(negedge clk);
        reset = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ifc1.done) done_cnt++;
        end
        check("rst_rd no_done", 32'(done_cnt), 32'd0);
        check("rst_rd mdr_after", ifc1.mdr, 32'd0);
        model_mdr[0] = '0; model_mdr[1] = '0;

        // Random accesses against the reference model
        for (int i = 0; i < 80; i++) begin
            int d;
            logic [2:0]  r_op;
            logic [31:0] r_addr, r_wdata, r_word;
            d = i % 2;
            r_op = 3'($urandom);
            r_addr = 32'($urandom_range(0, 32'h3FF));
            r_wdata = $urandom;
            r_word = $urandom;
            e = ref_model((d == 0) ? 1 : 3, r_op, r_addr, r_wdata, r_word, model_mdr[d]);
            run_and_check($sformatf("rnd%0d op%0d a%03h", i, r_op, r_addr), d, r_op, r_addr, r_wdata, r_word, e);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
